mem_stage_lsu: RTL and testbench

Parametrised load/store unit for the MEM stage. It takes one sized load or store per transaction from the pipeline and turns it into one or two aligned beats on a valid/ready memory port. It returns extended load data, or a completion, to the pipeline. It adds size/sign handling, byte strobes, cross-boundary splitting and backpressure, none of which the fixed 64-bit memory access path provides.

---
 rtl/mem_stage_lsu.sv | 214 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   MEM-stage load/store unit. Accepts one sized load or store from the
//   pipeline and issues it as one (aligned) or two (boundary-crossing) beats
//   on a valid/ready memory port. Loads return shifted and sign/zero-extended
//   data. Stores return a zero-data completion.
//
//   Optional feature macro: MEM_STAGE_LSU_MISALIGN_EN
//     defined   : accesses crossing a DATA_W boundary are split into two beats
//     undefined : such accesses complete immediately with resp_err=1
//
// Parameters
//   ADDR_W   byte-address width
//   DATA_W   memory bus width (power of two, 32..256)
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   req_valid/req_ready        pipeline request handshake
//   req_wen/addr/size/signed/wdata  request fields (size = log2 bytes)
//   resp_valid/rdata/err       one-cycle completion pulse with load data/error
//   mem_valid/mem_ready        beat request handshake
//   mem_wen/addr/wdata/wstrb   beat fields (addr is bus aligned)
//   mem_rvalid/mem_rdata       beat completion and read data
module mem_stage_lsu #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

`ifdef MEM_STAGE_LSU_MISALIGN_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ1  = 3'd1;
    localparam logic [2:0] WAIT1 = 3'd2;
    localparam logic [2:0] REQ2  = 3'd3;
    localparam logic [2:0] WAIT2 = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    logic [2:0]         state_q, state_d;
    logic               live_q;     // holds req_ready low until the first clock after reset
    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic               wen_q;
    logic               err_q;
    logic               cross_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  lo_q;
    logic [DATA_W-1:0]  hi_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    int unsigned req_n;
    int unsigned req_end;
    logic        req_too_big;
    logic        req_cross;
    logic        req_err;
    logic        accept;

    always_comb begin
        req_n       = 32'd1 << req_size;
        req_end     = 32'(req_addr[OFF_W-1:0]) + req_n;
        req_too_big = (req_n > BYTES);
        req_cross   = (req_end > BYTES);
        req_err     = req_too_big || (!SPLIT_EN && req_cross);
    end

    assign req_ready = live_q && (state_q == IDLE);
    assign accept    = req_ready && req_valid;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
            cross_q  <= 1'b0;
            wdata_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                wen_q    <= req_wen;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                cross_q  <= req_cross;
                lo_q     <= '0;
                hi_q     <= '0;   // single-beat loads see a zero upper beat
            end
            if (state_q == WAIT1 && mem_rvalid) begin
                lo_q <= mem_rdata;
            end
            if (state_q == WAIT2 && mem_rvalid) begin
                hi_q <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_err ? RESP : REQ1;
            REQ1:    if (mem_ready) state_d = WAIT1;
            WAIT1:   if (mem_rvalid) state_d = (SPLIT_EN && cross_q) ? REQ2 : RESP;
            REQ2:    if (mem_ready) state_d = WAIT2;
            WAIT2:   if (mem_rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat formation: the access is shifted into a double-width window so
    // the low half is beat 1 and the high half is beat 2 of a split access.
    // ------------------------------------------------------------------
    logic [OFF_W-1:0]    off_q;
    logic [ADDR_W-1:0]   base_addr;
    logic [2*BYTES-1:0]  strb_wide;
    logic [2*DATA_W-1:0] data_wide;
    logic                in_req1;
    logic                in_req2;

    always_comb begin
        off_q     = addr_q[OFF_W-1:0];
        base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        strb_wide = (((2*BYTES)'(1) << (32'd1 << size_q)) - (2*BYTES)'(1)) << off_q;
        data_wide = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
        in_req1   = (state_q == REQ1);
        in_req2   = (state_q == REQ2);
    end

    always_comb begin
        mem_valid = in_req1 || in_req2;
        mem_wen   = mem_valid && wen_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (in_req1) begin
            mem_addr  = base_addr;
            mem_wdata = data_wide[DATA_W-1:0];
            mem_wstrb = wen_q ? strb_wide[BYTES-1:0] : '0;
        end else if (in_req2) begin
            mem_addr  = base_addr + ADDR_W'(BYTES);
            mem_wdata = data_wide[2*DATA_W-1:DATA_W];
            mem_wstrb = wen_q ? strb_wide[2*BYTES-1:BYTES] : '0;
        end
    end

    // ------------------------------------------------------------------
    // Load result: align, keep n bytes, then extend from the top kept bit
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_keep;
    logic [DATA_W-1:0] ld_ext;
    int unsigned       ld_bits;
    logic              ld_sign;

    always_comb begin
        ld_bits  = 32'd8 << size_q;
        ld_shift = DATA_W'({hi_q, lo_q} >> {off_q, 3'b000});
        ld_keep  = (ld_bits >= DATA_W) ? '1 : ((DATA_W'(1) << ld_bits) - DATA_W'(1));
        // ld_keep & ~(ld_keep >> 1) isolates the most significant kept bit
        ld_sign  = signed_q && (|(ld_shift & ld_keep & ~(ld_keep >> 1)));
        ld_ext   = (ld_shift & ld_keep) | (ld_sign ? ~ld_keep : '0);
    end

    always_comb begin
        resp_valid = (state_q == RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !wen_q) ? ld_ext : '0;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with DATA_W=64.
// The memory side is driven directly by each scenario task.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wdata);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL release_req_ready got %b want 0", req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL first_clk_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_aligned_load();
        mem_ready = 1'b1;
        issue(1'b0, 64'h1000, 2'd3, 1'b0, 64'h0);
        // T+1
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL al_mem_valid got %b want 1", mem_valid); end
        checks++; if (mem_addr !== 64'h1000) begin errors++; $display("FAIL al_mem_addr got %h want 1000", mem_addr); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL al_mem_wen got %b want 0", mem_wen); end
        checks++; if (mem_wstrb !== 8'h00) begin errors++; $display("FAIL al_wstrb got %h want 00", mem_wstrb); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL al_req_ready got %b want 0", req_ready); end
        tick();
        // T+2: WAIT1
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL al_wait_mem_valid got %b want 0", mem_valid); end
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h8877665544332211;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        // T+3: RESP
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL al_resp_valid got %b want 1", resp_valid); end
        checks++; if (resp_rdata !== 64'h8877665544332211) begin errors++; $display("FAIL al_rdata got %h want 8877665544332211", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL al_err got %b want 0", resp_err); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL al_resp_req_ready got %b want 0", req_ready); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL al_resp_pulse got %b want 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL al_idle_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_signed_load();
        logic [63:0] v_addr  [3];
        logic [1:0]  v_size  [3];
        logic        v_sgn   [3];
        logic [63:0] v_rdata [3];
        logic [63:0] v_exp   [3];
        v_addr[0] = 64'h1006; v_size[0] = 2'd0; v_sgn[0] = 1'b1; v_rdata[0] = 64'h00F3000000000000; v_exp[0] = 64'hFFFFFFFFFFFFFFF3;
        v_addr[1] = 64'h1006; v_size[1] = 2'd0; v_sgn[1] = 1'b0; v_rdata[1] = 64'h00F3000000000000; v_exp[1] = 64'h00000000000000F3;
        v_addr[2] = 64'h1002; v_size[2] = 2'd1; v_sgn[2] = 1'b1; v_rdata[2] = 64'h0000000080010000; v_exp[2] = 64'hFFFFFFFFFFFF8001;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, v_addr[i], v_size[i], v_sgn[i], 64'h0);
            checks++; if (mem_addr !== 64'h1000) begin errors++; $display("FAIL sl%0d_mem_addr got %h want 1000", i, mem_addr); end
            checks++; if (mem_wstrb !== 8'h00) begin errors++; $display("FAIL sl%0d_wstrb got %h want 00", i, mem_wstrb); end
            tick();
            mem_rvalid = 1'b1;
            mem_rdata  = v_rdata[i];
            tick();
            mem_rvalid = 1'b0;
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sl%0d_resp_valid got %b want 1", i, resp_valid); end
            checks++; if (resp_rdata !== v_exp[i]) begin errors++; $display("FAIL sl%0d_rdata got %h want %h", i, resp_rdata, v_exp[i]); end
            tick();
        end
    endtask

    task automatic test_split_store();
        mem_ready = 1'b1;
        issue(1'b1, 64'h1006, 2'd2, 1'b0, 64'h00000000AABBCCDD);
`ifdef MEM_STAGE_LSU_MISALIGN_EN
        // T+1: beat 1
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL sp_b1_valid got %b want 1", mem_valid); end
        checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL sp_b1_wen got %b want 1", mem_wen); end
        checks++; if (mem_addr !== 64'h1000) begin errors++; $display("FAIL sp_b1_addr got %h want 1000", mem_addr); end
        checks++; if (mem_wstrb !== 8'hC0) begin errors++; $display("FAIL sp_b1_wstrb got %h want c0", mem_wstrb); end
        checks++; if (mem_wdata !== 64'hCCDD000000000000) begin errors++; $display("FAIL sp_b1_wdata got %h want ccdd000000000000", mem_wdata); end
        tick();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        // T+3: beat 2
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL sp_b2_valid got %b want 1", mem_valid); end
        checks++; if (mem_addr !== 64'h1008) begin errors++; $display("FAIL sp_b2_addr got %h want 1008", mem_addr); end
        checks++; if (mem_wstrb !== 8'h03) begin errors++; $display("FAIL sp_b2_wstrb got %h want 03", mem_wstrb); end
        checks++; if (mem_wdata !== 64'h000000000000AABB) begin errors++; $display("FAIL sp_b2_wdata got %h want aabb", mem_wdata); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sp_t4_resp got %b want 0", resp_valid); end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        // T+5
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sp_resp_valid got %b want 1", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL sp_resp_err got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL sp_resp_rdata got %h want 0", resp_rdata); end
`else
        // T+1: immediate error, no beat
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL sp_err_mem_valid got %b want 0", mem_valid); end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sp_err_resp_valid got %b want 1", resp_valid); end
        checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL sp_err_resp_err got %b want 1", resp_err); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL sp_err_rdata got %h want 0", resp_rdata); end
`endif
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sp_after_resp got %b want 0", resp_valid); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL sp_after_mem_valid got %b want 0", mem_valid); end
    endtask

    task automatic test_backpressure();
        mem_ready = 1'b0;
        issue(1'b1, 64'h2008, 2'd3, 1'b0, 64'h0102030405060708);
        for (int c = 0; c < 3; c++) begin
            // stray rvalid outside WAIT states must be ignored
            mem_rvalid = (c == 1);
            checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_valid got %b want 1", c, mem_valid); end
            checks++; if (mem_addr !== 64'h2008) begin errors++; $display("FAIL bp%0d_addr got %h want 2008", c, mem_addr); end
            checks++; if (mem_wdata !== 64'h0102030405060708) begin errors++; $display("FAIL bp%0d_wdata got %h want 0102030405060708", c, mem_wdata); end
            checks++; if (mem_wstrb !== 8'hFF) begin errors++; $display("FAIL bp%0d_wstrb got %h want ff", c, mem_wstrb); end
            tick();
        end
        mem_rvalid = 1'b0;
        mem_ready  = 1'b1;
        // T+4: handshake cycle
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL bp_hs_valid got %b want 1", mem_valid); end
        tick();
        // T+5: WAIT1
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_t5_resp got %b want 0", resp_valid); end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        // T+6
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_valid got %b want 1", resp_valid); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL bp_resp_rdata got %h want 0", resp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b1;
        issue(1'b0, 64'h3000, 2'd3, 1'b0, 64'h0);
        tick();
        // now in WAIT1; assert reset between edges
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_req_ready got %b want 0", req_ready); end
        checks++; if (mem_valid !== 1'b0 || mem_wen !== 1'b0) begin errors++; $display("FAIL rm_mem_ctl got %b%b want 00", mem_valid, mem_wen); end
        checks++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_wstrb !== 8'h0) begin errors++; $display("FAIL rm_mem_bus got %h %h %h want 0 0 0", mem_addr, mem_wdata, mem_wstrb); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'h0) begin errors++; $display("FAIL rm_resp got %b %b %h want 0 0 0", resp_valid, resp_err, resp_rdata); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_after got %b want 1", req_ready); end
        issue(1'b0, 64'h3010, 2'd2, 1'b0, 64'h0);
        checks++; if (mem_addr !== 64'h3010) begin errors++; $display("FAIL rm_new_addr got %h want 3010", mem_addr); end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1122334455667788;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rm_resp_valid got %b want 1", resp_valid); end
        checks++; if (resp_rdata !== 64'h0000000055667788) begin errors++; $display("FAIL rm_rdata got %h want 0000000055667788", resp_rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_signed_load();
        test_split_store();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
